// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width, result word type, opcodes, pointer helper.
package alu_pkg;

  localparam int unsigned DEFAULT_DATA_IN_WIDTH = 8;

  // ALU result word: operand width plus the carry/borrow bit in the MSB
  typedef logic [DEFAULT_DATA_IN_WIDTH:0] result_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  // Next value of a circular pointer: DEPTH-1 wraps to 0, so any DEPTH works
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Registered circular pointer that advances on inc and wraps at DEPTH-1.
module fifo_ptr_wrap
  import alu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          arst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // Pointer register with wrap
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= PW'(wrap_inc(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO buffering ALU results with occupancy count and almost-full flag.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter  int unsigned DATA_IN_WIDTH = DEFAULT_DATA_IN_WIDTH,
  parameter  int unsigned DEPTH         = 4,
  parameter  int unsigned AF_LEVEL      = 3,
  localparam int unsigned WW            = DATA_IN_WIDTH + 1,
  localparam int unsigned CW            = $clog2(DEPTH + 1),
  localparam int unsigned PW            = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          arst_n,
  input  logic [WW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [WW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full
);

  // Same layout as alu_pkg::result_t, sized by this instance's width
  typedef logic [WW-1:0] word_t;

  word_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  rd_ptr_nxt;
  logic [CW-1:0]  count_nxt;
  word_t          head_nxt;
  logic           push;
  logic           pop;

  // Handshakes use only registered flags, so out_ready never reaches in_ready
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i  (clk_i),
    .arst_n (arst_n),
    .inc    (push),
    .ptr    (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i  (clk_i),
    .arst_n (arst_n),
    .inc    (pop),
    .ptr    (rd_ptr)
  );

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Next occupancy and next head word; the head slot may be the one written this cycle
  always_comb begin
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    head_nxt   = '0;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    if (pop) begin
      rd_ptr_nxt = PW'(wrap_inc(32'(rd_ptr), DEPTH));
    end
    if (count_nxt != '0) begin
      head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? in_data : mem[rd_ptr_nxt];
    end
  end

  // Registered count, status flags and head-of-queue outputs
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      count       <= count_nxt;
      full        <= (count_nxt == CW'(DEPTH));
      empty       <= (count_nxt == '0);
      almost_full <= (count_nxt >= CW'(AF_LEVEL));
      in_ready    <= (count_nxt != CW'(DEPTH));
      out_valid   <= (count_nxt != '0);
      out_data    <= head_nxt;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: cycle vector table, scoreboard, corner sequences.
module tb_alu_result_fifo;

  logic       clk_i = 1'b0;
  logic       arst_n;
  logic [8:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [8:0]  sb[$];

  typedef struct {
    logic       iv;
    logic [8:0] d;
    logic       ordy;
    logic [2:0] cnt;
    logic [8:0] od;
    logic       fl;
    logic       em;
    logic       af;
  } vec_t;

  vec_t tbl[$];

  alu_result_fifo #(
    .DATA_IN_WIDTH (8),
    .DEPTH         (4),
    .AF_LEVEL      (3)
  ) dut (
    .clk_i       (clk_i),
    .arst_n      (arst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: scoreboard at the falling edge, then return 1 time unit after the rising edge
  task automatic cyc();
    logic [8:0] exp;
    @(negedge clk_i);
    if (arst_n) begin
      chk("no_overflow", 32'(in_valid && in_ready && full), 32'(0));
      chk("no_underflow", 32'(out_valid && out_ready && empty), 32'(0));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_pop", 32'(out_data), 32'h1ff0);
        end else begin
          exp = sb.pop_front();
          chk("sb_order", 32'(out_data), 32'(exp));
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(input logic iv, input logic [8:0] d, input logic ordy, input logic [2:0] cnt,
                     input logic [8:0] od, input logic fl, input logic em, input logic af);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.cnt = cnt;
    v.od = od; v.fl = fl; v.em = em; v.af = af;
    tbl.push_back(v);
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'(1));
    chk({tag, "_full"}, 32'(full), 32'(0));
    chk({tag, "_af"}, 32'(almost_full), 32'(0));
    chk({tag, "_count"}, 32'(count), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_data"}, 32'(out_data), 32'(0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    arst_n    = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    //            iv    d       ordy  cnt   od      fl    em    af
    add(1'b1, 9'h1FF, 1'b0, 3'd1, 9'h1FF, 1'b0, 1'b0, 1'b0);
    add(1'b1, 9'h000, 1'b0, 3'd2, 9'h1FF, 1'b0, 1'b0, 1'b0);
    add(1'b1, 9'h155, 1'b0, 3'd3, 9'h1FF, 1'b0, 1'b0, 1'b1);
    add(1'b0, 9'h000, 1'b1, 3'd2, 9'h000, 1'b0, 1'b0, 1'b0);
    add(1'b0, 9'h000, 1'b1, 3'd1, 9'h155, 1'b0, 1'b0, 1'b0);
    add(1'b0, 9'h000, 1'b1, 3'd0, 9'h000, 1'b0, 1'b1, 1'b0);
    add(1'b1, 9'h011, 1'b0, 3'd1, 9'h011, 1'b0, 1'b0, 1'b0);
    add(1'b1, 9'h022, 1'b0, 3'd2, 9'h011, 1'b0, 1'b0, 1'b0);
    add(1'b1, 9'h033, 1'b0, 3'd3, 9'h011, 1'b0, 1'b0, 1'b1);
    add(1'b1, 9'h044, 1'b0, 3'd4, 9'h011, 1'b1, 1'b0, 1'b1);
    add(1'b1, 9'h055, 1'b0, 3'd4, 9'h011, 1'b1, 1'b0, 1'b1);
    add(1'b0, 9'h000, 1'b1, 3'd3, 9'h022, 1'b0, 1'b0, 1'b1);
    add(1'b0, 9'h000, 1'b1, 3'd2, 9'h033, 1'b0, 1'b0, 1'b0);
    add(1'b0, 9'h000, 1'b1, 3'd1, 9'h044, 1'b0, 1'b0, 1'b0);
    add(1'b0, 9'h000, 1'b1, 3'd0, 9'h000, 1'b0, 1'b1, 1'b0);
    add(1'b1, 9'h0C1, 1'b0, 3'd1, 9'h0C1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 9'h0C2, 1'b0, 3'd2, 9'h0C1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 9'h0AA, 1'b1, 3'd2, 9'h0C2, 1'b0, 1'b0, 1'b0);
    add(1'b0, 9'h000, 1'b1, 3'd1, 9'h0AA, 1'b0, 1'b0, 1'b0);
    add(1'b0, 9'h000, 1'b1, 3'd0, 9'h000, 1'b0, 1'b1, 1'b0);

    // Power-on reset
    repeat (2) @(posedge clk_i);
    #1;
    chk_idle_state("por");
    arst_n = 1'b1;

    // Cycle table: push/pop patterns, full, almost-full, simultaneous push/pop
    foreach (tbl[i]) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      cyc();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(!tbl[i].em));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].fl));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].em));
      chk($sformatf("v%0d_af", i), 32'(almost_full), 32'(tbl[i].af));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(!tbl[i].fl));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Streaming through pointer wrap: occupancy never exceeds one
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 9'(9'h180 + k);
      cyc();
      chk($sformatf("wrap%0d_count_le1", k), 32'(count <= 3'd1), 32'(1));
    end
    in_valid = 1'b0;
    cyc();
    chk("wrap_drained", 32'(empty), 32'(1));

    // Sink stall: head must hold steady
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 9'h100;
    cyc();
    in_data   = 9'h101;
    cyc();
    in_valid  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("stall%0d_out_data", k), 32'(out_data), 32'h100);
      chk($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10 && out_valid; k++) cyc();
    chk("stall_drained", 32'(empty), 32'(1));
    out_ready = 1'b0;

    // Asynchronous reset in the middle of traffic
    in_valid = 1'b1;
    in_data  = 9'h1E1;
    cyc();
    in_data  = 9'h1E2;
    cyc();
    in_data  = 9'h1E3;
    #2;
    arst_n = 1'b0;
    #1;
    chk_idle_state("mid_rst");
    sb.delete();
    cyc();
    cyc();
    in_valid = 1'b0;
    arst_n   = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("post_rst%0d_out_valid", k), 32'(out_valid), 32'(0));
      chk($sformatf("post_rst%0d_count", k), 32'(count), 32'(0));
    end

    // Still functional after reset
    in_valid = 1'b1;
    in_data  = 9'h0A5;
    cyc();
    in_valid = 1'b0;
    chk("post_rst_head", 32'(out_data), 32'h0A5);
    cyc();
    chk("post_rst_empty", 32'(empty), 32'(1));
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
